// File: rtl/moving_avg_filter_if.sv
// Sample-in / average-out bundle for moving_avg_filter: the source side drives
// samples and clear, the filter side returns the SMA/EMA results and fill status.
interface moving_avg_filter_if #(
    parameter int DW     = 8,
    parameter int LOG2_N = 3
);
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              clear;
    logic [DW-1:0]     sma_out;
    logic [DW-1:0]     ema_out;
    logic              out_valid;
    logic              window_full;
    logic [LOG2_N:0]   fill_count;

    modport master (
        output in_valid,
        output in_data,
        output clear,
        input  sma_out,
        input  ema_out,
        input  out_valid,
        input  window_full,
        input  fill_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  clear,
        output sma_out,
        output ema_out,
        output out_valid,
        output window_full,
        output fill_count
    );
endinterface

// File: rtl/moving_avg_filter.sv
// Streaming SMA (2^LOG2_N window) and EMA (alpha = 2^-EMA_SHIFT) averager; results one cycle after accept.
// No backpressure: every in_valid cycle without clear is consumed; clear drops that cycle's sample.
module moving_avg_filter #(
    parameter int DW        = 8,
    parameter int LOG2_N    = 3,
    parameter int EMA_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    moving_avg_filter_if.slave bus
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = DW + LOG2_N;
    localparam int AW = DW + EMA_SHIFT;
    localparam logic [LOG2_N:0] FULL = (LOG2_N + 1)'(N);

    logic [DW-1:0]     win_buf [N];
    logic [LOG2_N-1:0] wptr;
    logic [SW-1:0]     sum;
    logic [AW-1:0]     acc;
    logic              seeded;
    logic [LOG2_N:0]   fill_count;
    logic [DW-1:0]     sma_q;
    logic [DW-1:0]     ema_q;
    logic              out_valid_q;

    logic              accept;
    logic [DW-1:0]     evict;
    logic [SW-1:0]     sum_next;
    logic [LOG2_N:0]   fill_next;
    logic [AW-1:0]     acc_next;
    logic [DW-1:0]     sma_next;
    logic [DW-1:0]     ema_next;

    assign accept = bus.in_valid && !bus.clear;

    always_comb begin
        evict     = win_buf[wptr];
        // Evicted slots are still zero while filling, so the running sum stays exact.
        sum_next  = sum - SW'(evict) + SW'(bus.in_data);
        fill_next = (fill_count == FULL) ? fill_count : fill_count + 1'b1;
        if (seeded) begin
            // acc stays <= (2^DW-1)*2^K, so this never wraps in AW bits.
            acc_next = acc - (acc >> EMA_SHIFT) + AW'(bus.in_data);
        end else begin
            acc_next = {bus.in_data, {EMA_SHIFT{1'b0}}};
        end
        sma_next = (fill_next == FULL) ? sum_next[SW-1:LOG2_N] : '0;
        ema_next = acc_next[AW-1:EMA_SHIFT];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) win_buf[i] <= '0;
            wptr        <= '0;
            sum         <= '0;
            acc         <= '0;
            seeded      <= 1'b0;
            fill_count  <= '0;
            sma_q       <= '0;
            ema_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i < N; i++) win_buf[i] <= '0;
            wptr        <= '0;
            sum         <= '0;
            acc         <= '0;
            seeded      <= 1'b0;
            fill_count  <= '0;
            sma_q       <= '0;
            ema_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            win_buf[wptr] <= bus.in_data;
            wptr          <= wptr + 1'b1;
            sum           <= sum_next;
            acc           <= acc_next;
            seeded        <= 1'b1;
            fill_count    <= fill_next;
            sma_q         <= sma_next;
            ema_q         <= ema_next;
            out_valid_q   <= 1'b1;
        end else begin
            out_valid_q   <= 1'b0;
        end
    end

    assign bus.sma_out     = sma_q;
    assign bus.ema_out     = ema_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.fill_count  = fill_count;
    assign bus.window_full = (fill_count == FULL);
endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed-vector bench for moving_avg_filter at DW=8, N=8, K=2.
module tb_moving_avg_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses;

    always #5 clk = ~clk;

    moving_avg_filter_if #(.DW(8), .LOG2_N(3)) bus ();

    moving_avg_filter #(.DW(8), .LOG2_N(3), .EMA_SHIFT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with results settled.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".sma"},  32'(bus.sma_out), 0);
        check({tag, ".ema"},  32'(bus.ema_out), 0);
        check({tag, ".ov"},   32'(bus.out_valid), 0);
        check({tag, ".full"}, 32'(bus.window_full), 0);
        check({tag, ".fill"}, 32'(bus.fill_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clear    = 1'b0;

        // Reset state and asynchronous mid-stream reset
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        step(1, 8'd10, 0);
        step(1, 8'd20, 0);
        step(1, 8'd30, 0);
        step(1, 8'd40, 0);
        check("pre_rst.ov", 32'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        step(0, 8'd0, 0);
        check("idle.ov", 32'(bus.out_valid), 0);
        step(1, 8'd50, 0);
        check("first.ema",  32'(bus.ema_out), 50);
        check("first.sma",  32'(bus.sma_out), 0);
        check("first.fill", 32'(bus.fill_count), 1);
        check("first.ov",   32'(bus.out_valid), 1);
        step(0, 8'd0, 0);
        check("first.ov_drop", 32'(bus.out_valid), 0);

        // SMA fill, wrap and eviction
        step(0, 8'd0, 1);
        check_zero("clr1");
        for (int i = 1; i <= 10; i++) begin
            step(1, 8'(i), 0);
            check("fill.cnt", 32'(bus.fill_count), (i < 8) ? i : 8);
            check("fill.full", 32'(bus.window_full), (i < 8) ? 0 : 1);
            check("fill.sma", 32'(bus.sma_out), (i < 8) ? 0 : (i - 4));
        end

        // EMA step response and convergence to full scale
        step(0, 8'd0, 1);
        step(1, 8'd100, 0);
        check("ema.s100", 32'(bus.ema_out), 100);
        step(1, 8'd0, 0);
        check("ema.s0a", 32'(bus.ema_out), 75);
        step(1, 8'd0, 0);
        check("ema.s0b", 32'(bus.ema_out), 56);
        for (int i = 1; i <= 40; i++) begin
            step(1, 8'd255, 0);
            if (i == 1)  check("ema.ramp1", 32'(bus.ema_out), 106);
            if (i == 20) check("ema.ramp20", 32'(bus.ema_out), 254);
            if (i >= 21) check("ema.hold", 32'(bus.ema_out), 255);
        end
        check("sat.sma", 32'(bus.sma_out), 255);

        // Fill count saturation
        for (int i = 0; i < 20; i++) begin
            step(1, 8'd255, 0);
            check("sat.fill", 32'(bus.fill_count), 8);
            check("sat.sma_hold", 32'(bus.sma_out), 255);
        end

        // Gapped handshake
        step(0, 8'd0, 1);
        step(1, 8'd16, 0);
        check("gap.ov1", 32'(bus.out_valid), 1);
        check("gap.ema1", 32'(bus.ema_out), 16);
        step(0, 8'd99, 0);
        check("gap.ov2", 32'(bus.out_valid), 0);
        check("gap.ema2", 32'(bus.ema_out), 16);
        check("gap.fill2", 32'(bus.fill_count), 1);
        step(0, 8'd99, 0);
        check("gap.ov3", 32'(bus.out_valid), 0);
        check("gap.ema3", 32'(bus.ema_out), 16);
        step(1, 8'd32, 0);
        check("gap.ov4", 32'(bus.out_valid), 1);
        check("gap.ema4", 32'(bus.ema_out), 20);
        check("gap.fill4", 32'(bus.fill_count), 2);
        check("gap.sma4", 32'(bus.sma_out), 0);

        // Continuous stream of 16 samples
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i * 3), 0);
            if (bus.out_valid === 1'b1) pulses++;
        end
        check("burst.pulses", 32'(pulses), 16);
        check("burst.full", 32'(bus.window_full), 1);
        step(0, 8'd0, 0);
        check("burst.ov_end", 32'(bus.out_valid), 0);

        // Clear wins over a simultaneous sample
        step(1, 8'd200, 1);
        check_zero("clrpri");
        step(1, 8'd8, 0);
        check("clrpri.ema",  32'(bus.ema_out), 8);
        check("clrpri.fill", 32'(bus.fill_count), 1);
        check("clrpri.ov",   32'(bus.out_valid), 1);
        check("clrpri.sma",  32'(bus.sma_out), 0);
        step(0, 8'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
